// File: rtl/cmd_deframer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_deframer_pkg
// Brief    : Shared constants, FSM state encoding and helpers for the
//            command deframer.
// Revision : 1.0 - initial release
// ============================================================================
package cmd_deframer_pkg;

  // Default start-of-packet marker.
  localparam logic [7:0] c_SYNC_BYTE = 8'hA5;

  // Width of the error and packet counters.
  localparam int c_CNT_W = 8;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam int c_ST_W = 3;
  typedef logic [c_ST_W-1:0] state_t;

  localparam logic [2:0] c_ST_HUNT    = 3'd0;
  localparam logic [2:0] c_ST_LEN     = 3'd1;
  localparam logic [2:0] c_ST_PAYLOAD = 3'd2;
  localparam logic [2:0] c_ST_CHECK   = 3'd3;
  localparam logic [2:0] c_ST_FETCH   = 3'd4;
  localparam logic [2:0] c_ST_PRESENT = 3'd5;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [c_CNT_W-1:0] sat_inc(input logic [c_CNT_W-1:0] v);
    return (v == '1) ? v : v + c_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_deframer_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_deframer_if
// Brief    : Byte-stream handshake and status bundle of the command deframer.
//            slave = deframer side, master = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface cmd_deframer_if;
  import cmd_deframer_pkg::*;

  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_next;
  logic               out_valid;
  logic [7:0]         out_data;
  logic               out_next;
  logic               err_pulse;
  logic [c_CNT_W-1:0] err_count;
  logic [c_CNT_W-1:0] pkt_count;

  modport slave (
    input  in_valid, in_data, out_next,
    output in_next, out_valid, out_data, err_pulse, err_count, pkt_count
  );

  modport master (
    output in_valid, in_data, out_next,
    input  in_next, out_valid, out_data, err_pulse, err_count, pkt_count
  );

endinterface
`default_nettype wire

// File: rtl/cmd_deframer_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp
// Brief    : Simple dual-port RAM, one write port and one read port with a
//            1-cycle registered read. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dp #(
  parameter int    Depth     = 256,
  parameter int    AddrWidth = 8,
  parameter int    Width     = 8,
  parameter string VendorRAM = ""
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AddrWidth-1:0] i_waddr,
  input  logic [Width-1:0]     i_wdata,
  input  logic                 i_re,
  input  logic [AddrWidth-1:0] i_raddr,
  output logic [Width-1:0]     o_rdata
);

  logic [Width-1:0] r_q;

  assign o_rdata = r_q;

  if (VendorRAM == "") begin : g_generic
    (* ram_style = "block" *) logic [Width-1:0] r_mem [Depth];

    // Inferred block RAM: write port plus registered read port.
    always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_q <= r_mem[i_raddr];
    end
  end else begin : g_vendor
    // A named vendor macro is bound at synthesis; this model keeps the same
    // cycle behaviour for simulation.
    (* ram_style = "auto" *) logic [Width-1:0] r_mem [Depth];

    // Behavioural stand-in for the vendor macro.
    always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_q <= r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmd_deframer.sv
`default_nettype none
// ============================================================================
// Module   : cmd_deframer
// Brief    : Validates SYNC/LEN/payload/CHK frames from the UART RX FIFO,
//            buffers the payload and forwards only good packets byte by byte.
//            Junk bytes and bad packets are dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_deframer
  import cmd_deframer_pkg::*;
#(
  parameter int         MaxLen    = 256,
  parameter int         AddrWidth = 8,
  parameter logic [7:0] SyncByte  = c_SYNC_BYTE,
  parameter string      VendorRAM = ""
) (
  input logic           clk,
  input logic           reset_n,
  cmd_deframer_if.slave bus
);

  localparam logic [8:0]         c_MAX_LEN  = 9'(MaxLen);
  localparam logic [AddrWidth:0] c_LEN_ONE  = (AddrWidth+1)'(1);
  localparam logic [AddrWidth-1:0] c_ADDR_ONE = AddrWidth'(1);

  state_t                 r_state;
  logic                   r_idle;      // forces the idle cycle after each pop
  logic [AddrWidth:0]     r_len;       // one extra bit so MaxLen itself fits
  logic [7:0]             r_sum;
  logic [AddrWidth-1:0]   r_wr_addr;
  logic [AddrWidth-1:0]   r_rd_addr;
  logic                   r_out_valid;
  logic                   r_err_pulse;
  logic [c_CNT_W-1:0]     r_err_count;
  logic [c_CNT_W-1:0]     r_pkt_count;

  logic                   w_consume;
  logic                   w_take;
  logic                   w_len_ok;
  logic                   w_chk_ok;
  logic                   w_err;
  logic [7:0]             w_chk_sum;
  logic [AddrWidth:0]     w_wr_next;
  logic [AddrWidth:0]     w_rd_next;
  logic [7:0]             w_ram_q;

  // Input is only taken while parsing; the single buffer blocks it while draining.
  assign w_consume = (r_state == c_ST_HUNT)    || (r_state == c_ST_LEN) ||
                     (r_state == c_ST_PAYLOAD) || (r_state == c_ST_CHECK);
  assign w_take    = bus.in_valid && !r_idle && w_consume;

  assign w_len_ok  = (bus.in_data != 8'h00) && ({1'b0, bus.in_data} <= c_MAX_LEN);
  assign w_chk_sum = r_sum + bus.in_data;
  assign w_chk_ok  = (w_chk_sum == 8'h00);
  assign w_wr_next = {1'b0, r_wr_addr} + c_LEN_ONE;
  assign w_rd_next = {1'b0, r_rd_addr} + c_LEN_ONE;

  assign w_err = w_take && (((r_state == c_ST_HUNT)  && (bus.in_data != SyncByte)) ||
                            ((r_state == c_ST_LEN)   && !w_len_ok) ||
                            ((r_state == c_ST_CHECK) && !w_chk_ok));

  assign bus.in_next   = w_take;
  assign bus.out_valid = r_out_valid;
  // RAM output is not reset, so mask it to read zero outside PRESENT.
  assign bus.out_data  = r_out_valid ? w_ram_q : 8'h00;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_count = r_err_count;
  assign bus.pkt_count = r_pkt_count;

  ram_dp #(
    .Depth     (MaxLen),
    .AddrWidth (AddrWidth),
    .Width     (8),
    .VendorRAM (VendorRAM)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_take && (r_state == c_ST_PAYLOAD)),
    .i_waddr (r_wr_addr),
    .i_wdata (bus.in_data),
    .i_re    (r_state == c_ST_FETCH),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_q)
  );

  // Frame parser and drain sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_ST_HUNT;
      r_idle      <= 1'b1;
      r_len       <= '0;
      r_sum       <= 8'h00;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_idle <= w_take;
      case (r_state)
        c_ST_HUNT: begin
          if (w_take && (bus.in_data == SyncByte)) r_state <= c_ST_LEN;
        end
        c_ST_LEN: begin
          if (w_take) begin
            if (w_len_ok) begin
              r_len     <= (AddrWidth+1)'(bus.in_data);
              r_sum     <= bus.in_data;
              r_wr_addr <= '0;
              r_state   <= c_ST_PAYLOAD;
            end else begin
              r_state <= c_ST_HUNT;
            end
          end
        end
        c_ST_PAYLOAD: begin
          if (w_take) begin
            r_sum     <= w_chk_sum;
            r_wr_addr <= r_wr_addr + c_ADDR_ONE;
            if (w_wr_next == r_len) r_state <= c_ST_CHECK;
          end
        end
        c_ST_CHECK: begin
          if (w_take) begin
            if (w_chk_ok) begin
              r_pkt_count <= r_pkt_count + c_CNT_W'(1);
              r_rd_addr   <= '0;
              r_state     <= c_ST_FETCH;
            end else begin
              r_state <= c_ST_HUNT;
            end
          end
        end
        c_ST_FETCH: begin
          r_out_valid <= 1'b1;
          r_state     <= c_ST_PRESENT;
        end
        c_ST_PRESENT: begin
          if (bus.out_next) begin
            r_out_valid <= 1'b0;
            r_rd_addr   <= r_rd_addr + c_ADDR_ONE;
            r_state     <= (w_rd_next == r_len) ? c_ST_HUNT : c_ST_FETCH;
          end
        end
        default: begin
          r_state     <= c_ST_HUNT;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Registered error strobe and saturating error counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) r_err_count <= sat_inc(r_err_count);
    end
  end

endmodule
`default_nettype wire
